// File: rtl/mux_8x1_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_8x1_pkg                                                          |
// | Shared sizing constants for the single-bit 8-to-1 multiplexer.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mux_8x1_pkg;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned N_IN  = 8;
endpackage
`default_nettype wire

// File: rtl/mux_8x1_mux_2x1.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_2x1                                                              |
// | Single-bit 2:1 select; y follows a when s is low, b when s is high.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mux_2x1 (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);
    assign y = s ? b : a;
endmodule
`default_nettype wire

// File: rtl/mux_8x1.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_8x1                                                              |
// | Single-bit 8:1 mux built as a 3-level 2:1 tree, plus a registered    |
// | copy of the output with synchronous active-high reset.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mux_8x1
    import mux_8x1_pkg::*;
(
    input  logic             in0,
    input  logic             in1,
    input  logic             in2,
    input  logic             in3,
    input  logic             in4,
    input  logic             in5,
    input  logic             in6,
    input  logic             in7,
    input  logic [SEL_W-1:0] sel,
    output logic             out,
    input  logic             clk,
    input  logic             reset,
    output logic             out_q
);
    logic [N_IN-1:0]   w_in;
    logic [N_IN/2-1:0] w_lvl0;
    logic [N_IN/4-1:0] w_lvl1;
    logic              w_out_q_d;

    assign w_in = {in7, in6, in5, in4, in3, in2, in1, in0};

    // Level 0: sel[0] chooses within each adjacent pair (2k, 2k+1).
    generate
        for (genvar k = 0; k < N_IN/2; k++) begin : g_lvl0
            mux_2x1 u_mux (
                .a (w_in[2*k]),
                .b (w_in[2*k+1]),
                .s (sel[0]),
                .y (w_lvl0[k])
            );
        end
        for (genvar k = 0; k < N_IN/4; k++) begin : g_lvl1
            mux_2x1 u_mux (
                .a (w_lvl0[2*k]),
                .b (w_lvl0[2*k+1]),
                .s (sel[1]),
                .y (w_lvl1[k])
            );
        end
    endgenerate

    mux_2x1 u_lvl2 (
        .a (w_lvl1[0]),
        .b (w_lvl1[1]),
        .s (sel[2]),
        .y (out)
    );

    assign w_out_q_d = reset ? 1'b0 : out;

    always_ff @(posedge clk) begin
        out_q <= w_out_q_d;
    end
endmodule
`default_nettype wire

// File: tb/tb_mux_8x1.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mux_8x1                                                           |
// | Directed self-checking bench for mux_8x1 (comb path and register).   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mux_8x1;
    logic       clk;
    logic       reset;
    logic [7:0] r_din;
    logic [2:0] r_sel;
    logic       w_out;
    logic       w_out_q;
    int         r_checks;
    int         r_errors;

    mux_8x1 u_dut (
        .in0   (r_din[0]),
        .in1   (r_din[1]),
        .in2   (r_din[2]),
        .in3   (r_din[3]),
        .in4   (r_din[4]),
        .in5   (r_din[5]),
        .in6   (r_din[6]),
        .in7   (r_din[7]),
        .sel   (r_sel),
        .out   (w_out),
        .clk   (clk),
        .reset (reset),
        .out_q (w_out_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        r_checks++;
        if (obs !== exp) begin
            r_errors++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] pat;
        r_checks = 0;
        r_errors = 0;
        reset    = 1'b1;
        r_din    = 8'h01;
        r_sel    = 3'd0;

        // Reset state: out_q cleared while out already follows in0.
        edge_sample();
        chk("reset_state_q", w_out_q, 1'b0);
        chk("reset_state_out", w_out, 1'b1);
        reset = 1'b0;

        // Walking one, matching and mismatching select.
        for (int p = 0; p < 8; p++) begin
            r_din = 8'h01 << p;
            r_sel = 3'(p);
            #1 chk("walk_hit", w_out, 1'b1);
            r_sel = 3'((p + 3) % 8);
            #1 chk("walk_miss", w_out, 1'b0);
        end

        // Exhaustive select x pattern.
        for (int s = 0; s < 8; s++) begin
            for (int v = 0; v < 256; v++) begin
                pat   = 8'(v);
                r_din = pat;
                r_sel = 3'(s);
                #1 chk("exhaustive", w_out, pat[s]);
            end
        end

        // Map column: in0..in6 = 1, in7 = 0.
        r_din = 8'b0111_1111;
        for (int s = 0; s < 7; s++) begin
            r_sel = 3'(s);
            #1 chk("mapcol_one", w_out, 1'b1);
        end
        r_sel = 3'd7;
        #1 chk("mapcol_sel7", w_out, 1'b0);

        // Isolation: only in3 may influence out when sel == 3.
        r_sel = 3'd3;
        for (int b = 0; b < 2; b++) begin
            for (int v = 0; v < 16; v++) begin
                pat    = 8'(v * 37 + 11);
                pat[3] = 1'(b);
                r_din  = pat;
                #1 chk("isolation", w_out, 1'(b));
            end
        end

        // Register and reset sequence.
        @(negedge clk);
        r_din = 8'h01;
        r_sel = 3'd0;
        reset = 1'b1;
        @(posedge clk);
        edge_sample();
        chk("rst_hold_q", w_out_q, 1'b0);
        chk("rst_hold_out", w_out, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        edge_sample();
        chk("rst_release_q", w_out_q, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        edge_sample();
        chk("rst_midstream_q", w_out_q, 1'b0);
        chk("rst_midstream_out", w_out, 1'b1);

        // Latency: in0 = 0, in7 = 1, switch sel 0 -> 7.
        @(negedge clk);
        reset = 1'b0;
        r_din = 8'h80;
        r_sel = 3'd0;
        edge_sample();
        chk("lat_base_q", w_out_q, 1'b0);
        @(negedge clk);
        r_sel = 3'd7;
        #1 chk("lat_out_now", w_out, 1'b1);
        chk("lat_q_not_yet", w_out_q, 1'b0);
        edge_sample();
        chk("lat_q_one_edge", w_out_q, 1'b1);

        $display("CHECKS %0d ERRORS %0d", r_checks, r_errors);
        $finish;
    end
endmodule
`default_nettype wire
